sm_dividend_rebuild: RTL and testbench
======================================

// Module: sm_dividend_rebuild
// PURPOSE
//  Inverse of the signed-magnitude remainder path: rebuilds the dividend from a
//  (quotient, divisor, remainder) triple as numerator = quotient*divisor + remainder.
//  Sequential shift-add over the 2 quotient magnitude bits, start/done handshake.
//  Used by the calculator's self-check to confirm division results.
//  Also flags triples that no legal truncating division could have produced.
// PARAMETERS
//  MAG_W   2  magnitude bits of quotient/divisor (sign bit is extra, MSB)
//  RES_W   4  magnitude bits of rebuilt numerator; must hold (2^MAG_W-1)^2+2^MAG_W-2
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  start        in   1      request; accepted only in IDLE
//  quotient     in   3      SM: [2] sign, [1:0] magnitude
//  denominator  in   3      SM: [2] sign, [1:0] magnitude
//  remainder    in   5      SM: [4] sign, [3:0] magnitude
//  busy         out  1      high from the cycle after acceptance until DONE exits
//  done         out  1      one-cycle pulse; results valid from this cycle
//  numerator    out  5      SM: [4] sign, [3:0] magnitude; held until next accept
//  invalid      out  1      triple rejected (see rules); numerator forced 0
//  zero         out  1      rebuilt magnitude == 0 and invalid == 0
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, invalid, zero = 0; numerator = 5'b0.
//  Operands are latched on acceptance; later input changes have no effect.
//  FSM: IDLE -start-> MUL0 -> MUL1 -> ADD -> DONE -> IDLE.
//   MUL0: acc = q[0] ? dmag : 0.   MUL1: acc += q[1] ? dmag<<1 : 0.
//   ADD:  acc += rem[3:0].   DONE: done=1, outputs loaded, busy=0 next cycle.
//  Latency: start accepted at cycle T -> done high at T+4 (valid) or T+1 (invalid).
//  Invalid at acceptance (IDLE -> DONE directly), any of:
//   denominator[1:0]==0; remainder[3:2]!=0; remainder[1:0] >= denominator[1:0];
//   quotient[1:0]!=0 and quotient[2] != (remainder[4] ^ denominator[2]).
//  Sign: numerator[4] = remainder[4]; forced 0 when magnitude is 0 (no -0 out).
//  Arithmetic unsigned on magnitudes, RES_W-bit acc; max 3*3+2=11, never overflows.
//  start in any state other than IDLE is ignored (no queueing).
//  start high in DONE cycle is ignored; a new request needs IDLE.
//  rst_n low mid-operation: immediate return to IDLE, all outputs to reset values.
//  done is never asserted without a preceding accepted start.
// STRUCTURE
//  Package sm_calc_pkg: state enum (IDLE, MUL0, MUL1, ADD, DONE), MAG_W/RES_W
//  localparams, SM field index constants shared with the remainder block.
//  One sub-module: sm_operand_check (combinational validity rules above).
//  FSM + accumulator + output registers stay in this module.
// TESTING
//  q=011, d=011, r=00010, start -> done at T+4, numerator=01011 (+11), zero=0.
//  q=101, d=010, r=10001 -> numerator=10011 (-3), invalid=0.
//  d=000 (any q, r) -> done at T+1, invalid=1, numerator=00000, zero=0.
//  q=001, d=010, r=00010 (r>=d) -> invalid=1; q=001, d=010, r=10001 -> invalid=1.
//  q=000, d=011, r=10000 -> numerator=00000, zero=1 (sign normalised).
//  start pulsed during MUL1, and rst_n dropped in ADD -> ignored / all reset.

Source files
------------

// File: rtl/sm_calc_pkg.sv
// sm_calc_pkg: shared widths, signed-magnitude field indices and FSM states for the calculator blocks
package sm_calc_pkg;
    localparam int MAG_W  = 2;
    localparam int RES_W  = 4;
    localparam int Q_SIGN = MAG_W;
    localparam int R_SIGN = RES_W;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL0 = 3'd1,
        MUL1 = 3'd2,
        ADD  = 3'd3,
        DONE = 3'd4
    } state_t;
endpackage

// File: rtl/sm_operand_check.sv
// sm_operand_check: flags (quotient, denominator, remainder) triples no truncating division can produce
// quotient/denominator: SM, sign at MSB; remainder: SM, sign at MSB; bad: triple rejected
module sm_operand_check
    import sm_calc_pkg::*;
(
    input  logic [MAG_W:0] quotient,
    input  logic [MAG_W:0] denominator,
    input  logic [RES_W:0] remainder,
    output logic           bad
);
    logic [MAG_W-1:0] d_mag;
    logic             sign_clash;
    always_comb begin
        d_mag      = denominator[MAG_W-1:0];
        // a zero quotient carries no sign information, so only nonzero quotients are sign-checked
        sign_clash = (quotient[MAG_W-1:0] != '0) &&
                     (quotient[Q_SIGN] != (remainder[R_SIGN] ^ denominator[Q_SIGN]));
        bad        = (d_mag == '0) || (remainder[RES_W-1:MAG_W] != '0) ||
                     (remainder[MAG_W-1:0] >= d_mag) || sign_clash;
    end
endmodule

// File: rtl/sm_dividend_rebuild.sv
// sm_dividend_rebuild: rebuilds numerator = quotient*denominator + remainder by sequential shift-add
// in: clk, rst_n, start, quotient[2:0], denominator[2:0], remainder[4:0] (all SM, sign at MSB)
// out: busy, done (1-cycle pulse), numerator[4:0] (SM), invalid, zero
module sm_dividend_rebuild
    import sm_calc_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [MAG_W:0] quotient,
    input  logic [MAG_W:0] denominator,
    input  logic [RES_W:0] remainder,
    output logic           busy,
    output logic           done,
    output logic [RES_W:0] numerator,
    output logic           invalid,
    output logic           zero
);
    state_t           state;
    logic             bad;
    logic [MAG_W-1:0] q_mag;
    logic [MAG_W-1:0] d_mag;
    logic             r_sign;
    logic [RES_W-1:0] r_mag;
    logic [RES_W-1:0] acc;
    logic [RES_W-1:0] sum;

    sm_operand_check u_check (
        .quotient    (quotient),
        .denominator (denominator),
        .remainder   (remainder),
        .bad         (bad)
    );

    always_comb begin
        busy = state != IDLE;
        done = state == DONE;
        sum  = acc + r_mag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            q_mag     <= '0;
            d_mag     <= '0;
            r_sign    <= 1'b0;
            r_mag     <= '0;
            acc       <= '0;
            numerator <= '0;
            invalid   <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    q_mag  <= quotient[MAG_W-1:0];
                    d_mag  <= denominator[MAG_W-1:0];
                    r_sign <= remainder[R_SIGN];
                    r_mag  <= remainder[RES_W-1:0];
                    // rejected triples skip the arithmetic and report straight away
                    if (bad) begin
                        numerator <= '0;
                        invalid   <= 1'b1;
                        zero      <= 1'b0;
                        state     <= DONE;
                    end else begin
                        state <= MUL0;
                    end
                end
                MUL0: begin
                    acc   <= q_mag[0] ? RES_W'(d_mag) : '0;
                    state <= MUL1;
                end
                MUL1: begin
                    acc   <= acc + (q_mag[1] ? RES_W'({d_mag, 1'b0}) : '0);
                    state <= ADD;
                end
                ADD: begin
                    // sign follows the remainder, but a zero magnitude is always reported as +0
                    numerator <= {r_sign && (sum != '0), sum};
                    invalid   <= 1'b0;
                    zero      <= sum == '0;
                    state     <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sm_dividend_rebuild.sv
// tb_sm_dividend_rebuild: table-driven and scoreboarded checks of sm_dividend_rebuild
module tb_sm_dividend_rebuild;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] quotient = '0;
    logic [2:0] denominator = '0;
    logic [4:0] remainder = '0;
    logic       busy;
    logic       done;
    logic [4:0] numerator;
    logic       invalid;
    logic       zero;

    typedef struct {
        logic [2:0] q;
        logic [2:0] d;
        logic [4:0] r;
        logic [4:0] num;
        logic       inv;
        logic       zero;
        int         lat;
    } vec_t;

    typedef struct {
        logic [4:0] num;
        logic       inv;
        logic       zero;
        int         lat;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    sm_dividend_rebuild dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .quotient    (quotient),
        .denominator (denominator),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .numerator   (numerator),
        .invalid     (invalid),
        .zero        (zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // drive one request; inputs are scrambled after acceptance to prove they were latched
    task automatic launch(input logic [2:0] q, input logic [2:0] d, input logic [4:0] r,
                          input exp_t e, input bit hold);
        @(negedge clk);
        quotient = q;
        denominator = d;
        remainder = r;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        quotient = ~q;
        denominator = ~d;
        remainder = ~r;
    endtask

    task automatic wait_done(input string tag, input int lat0);
        int   lat;
        exp_t e;
        lat = lat0;
        while (!done && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " done seen"}, int'(done), 1);
        if (sb.size() == 0) begin
            check({tag, " scoreboard entry"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({tag, " latency"}, lat, e.lat);
            check({tag, " numerator"}, int'(numerator), int'(e.num));
            check({tag, " invalid"}, int'(invalid), int'(e.inv));
            check({tag, " zero"}, int'(zero), int'(e.zero));
        end
        check({tag, " busy in done"}, int'(busy), 1);
        @(posedge clk);
        #1;
        check({tag, " done pulse width"}, int'(done), 0);
        check({tag, " busy after done"}, int'(busy), 0);
    endtask

    task automatic quiet(input string tag, input int n);
        bit seen;
        seen = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check({tag, " no spurious done"}, int'(seen), 0);
    endtask

    function automatic exp_t model(input logic [2:0] q, input logic [2:0] d, input logic [4:0] r);
        exp_t e;
        int   mag;
        bit   bad;
        bad = (d[1:0] == 0) || (r[3:2] != 0) || (r[1:0] >= d[1:0]) ||
              ((q[1:0] != 0) && (q[2] != (r[4] ^ d[2])));
        mag = int'(q[1:0]) * int'(d[1:0]) + int'(r[3:0]);
        e.inv  = bad;
        e.lat  = bad ? 1 : 4;
        e.zero = !bad && (mag == 0);
        e.num  = bad ? 5'd0 : {(mag != 0) && r[4], 4'(mag)};
        return e;
    endfunction

    initial begin
        exp_t e;
        vecs[0] = '{3'b011, 3'b011, 5'b00010, 5'b01011, 1'b0, 1'b0, 4};
        vecs[1] = '{3'b101, 3'b010, 5'b10001, 5'b10011, 1'b0, 1'b0, 4};
        vecs[2] = '{3'b011, 3'b000, 5'b00001, 5'b00000, 1'b1, 1'b0, 1};
        vecs[3] = '{3'b001, 3'b010, 5'b00010, 5'b00000, 1'b1, 1'b0, 1};
        vecs[4] = '{3'b001, 3'b010, 5'b10001, 5'b00000, 1'b1, 1'b0, 1};
        vecs[5] = '{3'b000, 3'b011, 5'b10000, 5'b00000, 1'b0, 1'b1, 4};
        vecs[6] = '{3'b010, 3'b001, 5'b00100, 5'b00000, 1'b1, 1'b0, 1};
        vecs[7] = '{3'b110, 3'b111, 5'b00010, 5'b01000, 1'b0, 1'b0, 4};

        #12;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset numerator", int'(numerator), 0);
        check("reset invalid", int'(invalid), 0);
        check("reset zero", int'(zero), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            e = '{vecs[i].num, vecs[i].inv, vecs[i].zero, vecs[i].lat};
            launch(vecs[i].q, vecs[i].d, vecs[i].r, e, 1'b0);
            wait_done($sformatf("vec%0d", i), 1);
        end

        for (int i = 0; i < 6; i++) begin
            logic [1:0] dm, qm, rm;
            logic       ds, rs, qs;
            dm = 2'($urandom_range(1, 3));
            qm = 2'($urandom_range(0, 3));
            rm = 2'($urandom_range(0, int'(dm) - 1));
            ds = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            qs = (qm != 0) ? (rs ^ ds) : 1'($urandom_range(0, 1));
            launch({qs, qm}, {ds, dm}, {rs, 2'b00, rm},
                   model({qs, qm}, {ds, dm}, {rs, 2'b00, rm}), 1'b0);
            wait_done($sformatf("rnd%0d", i), 1);
        end

        launch(3'b011, 3'b011, 5'b00010, model(3'b011, 3'b011, 5'b00010), 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        start = 1'b1;
        quotient = 3'b001;
        denominator = 3'b001;
        remainder = 5'b00000;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("start in MUL1", 3);
        quiet("start in MUL1", 6);

        launch(3'b001, 3'b000, 5'b00000, model(3'b001, 3'b000, 5'b00000), 1'b1);
        wait_done("start in DONE", 1);
        start = 1'b0;
        quiet("start in DONE", 6);

        launch(3'b010, 3'b011, 5'b00001, model(3'b010, 3'b011, 5'b00001), 1'b0);
        wait_done("pre-reset op", 1);
        launch(3'b011, 3'b011, 5'b00010, model(3'b011, 3'b011, 5'b00010), 1'b0);
        void'(sb.pop_front());
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset in ADD busy", int'(busy), 0);
        check("reset in ADD done", int'(done), 0);
        check("reset in ADD numerator", int'(numerator), 0);
        check("reset in ADD invalid", int'(invalid), 0);
        check("reset in ADD zero", int'(zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet("after reset", 6);
        launch(3'b101, 3'b010, 5'b10001, model(3'b101, 3'b010, 5'b10001), 1'b0);
        wait_done("after reset op", 1);

        check("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
